// File: rtl/wb_dest_hazard_tracker_pkg.sv
// ----------------------------------------------------------------------------
// wb_dest_hazard_tracker_pkg
//   Shared constants for the writeback-destination hazard tracker.
//   - Forwarding select encodings for the EX operand muxes.
//   - Architectural register numbers with special meaning.
//   - Default widths for the stage entry {dest, reg_write, mem_read}.
// ----------------------------------------------------------------------------
package wb_dest_hazard_tracker_pkg;

  localparam int REG_ADDR_W_DEF  = 5;
  localparam int STALL_CNT_W_DEF = 16;

  // Stage entry layout: dest field plus two flag bits (reg_write, mem_read).
  localparam int ENTRY_FLAG_W = 2;

  localparam int FWD_W = 2;
  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'd0;
  localparam fwd_sel_t FWD_MEM     = 2'd1;
  localparam fwd_sel_t FWD_WB      = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

endpackage

// File: rtl/wb_dest_hazard_tracker_if.sv
// ----------------------------------------------------------------------------
// wb_dest_hazard_tracker_if
//   Bundles the ID-stage hazard inputs and the tracker's results.
//   master : the pipeline control driving ID fields and consuming results
//   slave  : the tracker itself
//   ID side   : id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
//               id_reg_write, id_mem_read, flush
//   Results   : stall (comb), fwd_a, fwd_b (registered), ex_dest,
//               mem_dest, wb_dest, wb_reg_write, stall_count
// ----------------------------------------------------------------------------
interface wb_dest_hazard_tracker_if
  import wb_dest_hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
);

  logic [REG_ADDR_W-1:0]  id_rs;
  logic [REG_ADDR_W-1:0]  id_rt;
  logic                   id_uses_rs;
  logic                   id_uses_rt;
  logic [REG_ADDR_W-1:0]  id_dest;
  logic                   id_reg_write;
  logic                   id_mem_read;
  logic                   flush;

  logic                   stall;
  fwd_sel_t               fwd_a;
  fwd_sel_t               fwd_b;
  logic [REG_ADDR_W-1:0]  ex_dest;
  logic [REG_ADDR_W-1:0]  mem_dest;
  logic [REG_ADDR_W-1:0]  wb_dest;
  logic                   wb_reg_write;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, flush,
    input  stall, fwd_a, fwd_b, ex_dest, mem_dest, wb_dest,
           wb_reg_write, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_reg_write, id_mem_read, flush,
    output stall, fwd_a, fwd_b, ex_dest, mem_dest, wb_dest,
           wb_reg_write, stall_count
  );

endinterface

// File: rtl/wb_dest_hazard_tracker_hazard_stage_reg.sv
// ----------------------------------------------------------------------------
// hazard_stage_reg
//   One pipeline shadow entry {dest, reg_write, mem_read}.
//   Advances every cycle. bubble loads an all-zero entry, which can neither
//   forward nor cause a stall downstream.
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   bubble              : load {0,0,0} instead of d_*
//   d_dest/d_reg_write/d_mem_read : next entry
//   q_dest/q_reg_write/q_mem_read : current entry
// ----------------------------------------------------------------------------
module hazard_stage_reg #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic [REG_ADDR_W-1:0] d_dest,
  input  logic                  d_reg_write,
  input  logic                  d_mem_read,
  output logic [REG_ADDR_W-1:0] q_dest,
  output logic                  q_reg_write,
  output logic                  q_mem_read
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q_dest      <= '0;
      q_reg_write <= 1'b0;
      q_mem_read  <= 1'b0;
    end else begin
      q_dest      <= d_dest;
      q_reg_write <= d_reg_write;
      q_mem_read  <= d_mem_read;
    end
  end

endmodule

// File: rtl/wb_dest_hazard_tracker.sv
// ----------------------------------------------------------------------------
// wb_dest_hazard_tracker
//   Carries the ID-chosen write destination through EX/MEM/WB shadow stages,
//   detects load-use hazards against the ID source registers, produces the
//   registered EX forwarding selects and presents the WB write port.
// Ports
//   Clk    : system clock, rising edge
//   Reset  : synchronous, active-high; clears all entries, selects, counter
//   bus    : slave side of wb_dest_hazard_tracker_if (ID fields in,
//            stall/fwd/debug/writeback/statistics out)
// ----------------------------------------------------------------------------
module wb_dest_hazard_tracker
  import wb_dest_hazard_tracker_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  wb_dest_hazard_tracker_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(REG_ZERO);

  logic [REG_ADDR_W-1:0] ex_dest_q, mem_dest_q, wb_dest_q;
  logic                  ex_rw_q, mem_rw_q, wb_rw_q;
  logic                  ex_mr_q, mem_mr_q, wb_mr_q;

  logic                  stall_int;
  logic                  bubble;
  fwd_sel_t              fwd_a_d, fwd_b_d;
  fwd_sel_t              fwd_a_q, fwd_b_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Older stages only ever need dest/reg_write; their load flag is carried
  // for entry uniformity but has no consumer past EX.
  logic unused_mem_flags;
  assign unused_mem_flags = &{1'b0, mem_mr_q, wb_mr_q};

  // ---------------------------------------------------------------------
  // Shadow stages
  // ---------------------------------------------------------------------
  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk         (Clk),
    .reset       (Reset),
    .bubble      (bubble),
    .d_dest      (bus.id_dest),
    .d_reg_write (bus.id_reg_write),
    .d_mem_read  (bus.id_mem_read),
    .q_dest      (ex_dest_q),
    .q_reg_write (ex_rw_q),
    .q_mem_read  (ex_mr_q)
  );

  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk         (Clk),
    .reset       (Reset),
    .bubble      (1'b0),
    .d_dest      (ex_dest_q),
    .d_reg_write (ex_rw_q),
    .d_mem_read  (ex_mr_q),
    .q_dest      (mem_dest_q),
    .q_reg_write (mem_rw_q),
    .q_mem_read  (mem_mr_q)
  );

  hazard_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
    .clk         (Clk),
    .reset       (Reset),
    .bubble      (1'b0),
    .d_dest      (mem_dest_q),
    .d_reg_write (mem_rw_q),
    .d_mem_read  (mem_mr_q),
    .q_dest      (wb_dest_q),
    .q_reg_write (wb_rw_q),
    .q_mem_read  (wb_mr_q)
  );

  // ---------------------------------------------------------------------
  // Load-use detection: a load in EX cannot forward its data until MEM,
  // so a dependent ID instruction waits one cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    stall_int = 1'b0;
    if (ex_mr_q && (ex_dest_q != ZERO_REG)) begin
      stall_int = (bus.id_uses_rs && (ex_dest_q == bus.id_rs)) ||
                  (bus.id_uses_rt && (ex_dest_q == bus.id_rt));
    end
  end

  assign bubble = bus.flush | stall_int;

  // ---------------------------------------------------------------------
  // Forward select: evaluated against the pre-edge EX/MEM entries, which
  // become MEM/WB when the ID instruction reaches EX. EX is checked first
  // so the newest producer wins.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;

    if (bus.id_uses_rs) begin
      if (ex_rw_q && (ex_dest_q != ZERO_REG) && (ex_dest_q == bus.id_rs))
        fwd_a_d = FWD_MEM;
      else if (mem_rw_q && (mem_dest_q != ZERO_REG) && (mem_dest_q == bus.id_rs))
        fwd_a_d = FWD_WB;
    end

    if (bus.id_uses_rt) begin
      if (ex_rw_q && (ex_dest_q != ZERO_REG) && (ex_dest_q == bus.id_rt))
        fwd_b_d = FWD_MEM;
      else if (mem_rw_q && (mem_dest_q != ZERO_REG) && (mem_dest_q == bus.id_rt))
        fwd_b_d = FWD_WB;
    end

    // A bubble entering EX must not steer the operand muxes.
    if (bubble) begin
      fwd_a_d = FWD_REGFILE;
      fwd_b_d = FWD_REGFILE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  // ---------------------------------------------------------------------
  // Load-use statistics. A flushed ID instruction never really stalled,
  // so it is not counted. Saturates at all-ones.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (stall_int && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.stall        = stall_int;
  assign bus.fwd_a        = fwd_a_q;
  assign bus.fwd_b        = fwd_b_q;
  assign bus.ex_dest      = ex_dest_q;
  assign bus.mem_dest     = mem_dest_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_reg_write = wb_rw_q;
  assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_wb_dest_hazard_tracker.sv
// ----------------------------------------------------------------------------
// tb_wb_dest_hazard_tracker
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against a queue-based pipeline model.
//   The statistics counter is narrowed so saturation is reachable quickly.
// ----------------------------------------------------------------------------
module tb_wb_dest_hazard_tracker;
  import wb_dest_hazard_tracker_pkg::*;

  localparam int AW = 5;
  localparam int CW = 10;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_dest_hazard_tracker_if #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) bus ();

  wb_dest_hazard_tracker #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // Model: queue of instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    int dest;
    bit rw;
    bit mr;
  } ent_t;

  ent_t hist[$];
  int   exp_fwd_a, exp_fwd_b, exp_cnt;
  bit   model_ok = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    ent_t ex;
    ex = hist[0];
    if (!ex.mr || ex.dest == 0) return 1'b0;
    return (bus.id_uses_rs && ex.dest == int'(bus.id_rs)) ||
           (bus.id_uses_rt && ex.dest == int'(bus.id_rt));
  endfunction

  // Which stage will hold the most recent writer of src once the ID
  // instruction sits in EX: 1 = producer one ahead, 2 = two ahead.
  function automatic int model_sel(input bit uses, input int src);
    if (!uses || src == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (hist[age].rw && hist[age].dest == src) return age + 1;
    return 0;
  endfunction

  task automatic model_step();
    ent_t n;
    bit   st, bub;
    int   a, b;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back('{0, 1'b0, 1'b0});
      exp_fwd_a = 0;
      exp_fwd_b = 0;
      exp_cnt   = 0;
      model_ok  = 1'b1;
      return;
    end
    if (!model_ok) return;
    st  = model_stall();
    bub = bus.flush || st;
    a   = bub ? 0 : model_sel(bus.id_uses_rs, int'(bus.id_rs));
    b   = bub ? 0 : model_sel(bus.id_uses_rt, int'(bus.id_rt));
    if (st && !bus.flush && exp_cnt < CNT_MAX) exp_cnt++;
    if (bub) n = '{0, 1'b0, 1'b0};
    else     n = '{int'(bus.id_dest), bus.id_reg_write, bus.id_mem_read};
    hist.push_front(n);
    void'(hist.pop_back());
    exp_fwd_a = a;
    exp_fwd_b = b;
  endtask

  // Per-cycle compare, mid-cycle when inputs and registered outputs are stable.
  always @(negedge clk) begin
    if (model_ok) begin
      check("stall",        int'(bus.stall),        int'(model_stall()));
      check("fwd_a",        int'(bus.fwd_a),        exp_fwd_a);
      check("fwd_b",        int'(bus.fwd_b),        exp_fwd_b);
      check("ex_dest",      int'(bus.ex_dest),      hist[0].dest);
      check("mem_dest",     int'(bus.mem_dest),     hist[1].dest);
      check("wb_dest",      int'(bus.wb_dest),      hist[2].dest);
      check("wb_reg_write", int'(bus.wb_reg_write), int'(hist[2].rw));
      check("stall_count",  int'(bus.stall_count),  exp_cnt);
    end
  end

  // Apply one ID instruction for one cycle; returns stall as seen before the edge.
  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit rw, input bit mr, input bit fl,
                       output bit st_seen);
    bus.id_rs        = AW'(rs);
    bus.id_rt        = AW'(rt);
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_dest      = AW'(dest);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
    #3;
    st_seen = bus.stall;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic nop();
    bit d;
    issue(0, 0, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic random_cycles(input int n, input bit allow_reset);
    bit d;
    int v;
    for (int i = 0; i < n; i++) begin
      rst = allow_reset && ($urandom_range(0, 149) == 0);
      v = $urandom_range(0, 8);
      issue($urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (v == 8) ? int'(REG_LINK) : v,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0), d);
    end
    rst = 1'b0;
  endtask

  bit st;

  initial begin
    rst              = 1'b1;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_uses_rs   = 1'b0;
    bus.id_uses_rt   = 1'b0;
    bus.id_dest      = '0;
    bus.id_reg_write = 1'b0;
    bus.id_mem_read  = 1'b0;
    bus.flush        = 1'b0;
    nop();
    nop();
    rst = 1'b0;

    // Warm up with traffic so the following reset has state to discard.
    random_cycles(200, 1'b0);

    // Mid-stream reset held for two cycles while loads keep arriving.
    rst = 1'b1;
    issue(3, 3, 1, 1, 3, 1, 1, 0, st);
    issue(3, 3, 1, 1, 3, 1, 1, 0, st);
    check("rst_wb_reg_write", int'(bus.wb_reg_write), 0);
    check("rst_fwd_a",        int'(bus.fwd_a),        0);
    check("rst_fwd_b",        int'(bus.fwd_b),        0);
    check("rst_stall_count",  int'(bus.stall_count),  0);
    rst = 1'b0;
    issue(3, 3, 1, 1, 9, 1, 0, 0, st);
    check("rst_stall", int'(st), 0);
    check("rst_no_wb", int'(bus.wb_reg_write), 0);
    nop(); nop(); nop();

    // Back-to-back ALU dependency, then gaps of one and two.
    issue(0, 0, 0, 0, 5, 1, 0, 0, st);
    issue(5, 0, 1, 0, 6, 1, 0, 0, st);
    check("b2b_stall", int'(st), 0);
    check("b2b_fwd_a", int'(bus.fwd_a), 1);
    nop(); nop(); nop();
    issue(0, 0, 0, 0, 5, 1, 0, 0, st);
    nop();
    issue(5, 0, 1, 0, 6, 1, 0, 0, st);
    check("gap1_fwd_a", int'(bus.fwd_a), 2);
    nop(); nop(); nop();
    issue(0, 0, 0, 0, 5, 1, 0, 0, st);
    nop(); nop();
    issue(5, 0, 1, 0, 6, 1, 0, 0, st);
    check("gap2_fwd_a", int'(bus.fwd_a), 0);
    nop(); nop(); nop();

    // Newest producer wins when two in-flight writers share a destination.
    issue(0, 0, 0, 0, 6, 1, 0, 0, st);
    issue(0, 0, 0, 0, 6, 1, 0, 0, st);
    issue(0, 6, 0, 1, 7, 1, 0, 0, st);
    check("newest_fwd_b", int'(bus.fwd_b), 1);
    nop(); nop(); nop();

    // Load-use: one stall, bubble into EX, then forwarding from WB.
    issue(0, 0, 0, 0, 8, 1, 1, 0, st);
    issue(0, 8, 0, 1, 9, 1, 0, 0, st);
    check("lu_stall",       int'(st), 1);
    check("lu_ex_bubble",   int'(bus.ex_dest), 0);
    check("lu_stall_count", int'(bus.stall_count), 1);
    issue(0, 8, 0, 1, 9, 1, 0, 0, st);
    check("lu_retry_stall", int'(st), 0);
    check("lu_fwd_b",       int'(bus.fwd_b), 2);
    nop(); nop(); nop();

    // Register 0 is never a hazard, even for a load.
    issue(0, 0, 0, 0, 0, 1, 1, 0, st);
    issue(0, 0, 1, 1, 4, 1, 0, 0, st);
    check("r0_stall", int'(st), 0);
    check("r0_fwd_a", int'(bus.fwd_a), 0);
    check("r0_fwd_b", int'(bus.fwd_b), 0);
    nop(); nop(); nop();

    // Flush with a load-use in the same cycle: bubble, no count.
    issue(0, 0, 0, 0, 8, 1, 1, 0, st);
    issue(0, 8, 0, 1, 9, 1, 0, 1, st);
    check("fl_stall_count", int'(bus.stall_count), 1);
    check("fl_ex_bubble",   int'(bus.ex_dest), 0);
    check("fl_fwd_b",       int'(bus.fwd_b), 0);
    nop(); nop(); nop();

    // jal then jr $31.
    issue(0, 0, 0, 0, int'(REG_LINK), 1, 0, 0, st);
    issue(int'(REG_LINK), 0, 1, 0, 0, 0, 0, 0, st);
    check("link_fwd_a", int'(bus.fwd_a), 1);
    nop(); nop(); nop();

    // Self-dependent loads stall every other cycle; drive the counter to saturation.
    for (int i = 0; i < 2 * (CNT_MAX + 1) + 20; i++)
      issue(8, 0, 1, 0, 8, 1, 1, 0, st);
    check("sat_count", int'(bus.stall_count), CNT_MAX);
    for (int i = 0; i < 6; i++)
      issue(8, 0, 1, 0, 8, 1, 1, 0, st);
    check("sat_hold", int'(bus.stall_count), CNT_MAX);

    // Randomized traffic including occasional mid-stream resets.
    random_cycles(800, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
